psc_trigger_mux: RTL and testbench

// - Multi-channel successor of the single-input PSC trigger path.
// - Takes NUM_CH active-low EVR trigger inputs and queues one pending request per channel.
// - Arbitrates requests round-robin and serialises one framed, CRC-protected message per trigger onto psc_output.
// - Single clock domain; the bit rate comes from an internal clock-enable divider, so no PLL clocks are needed.

---
 rtl/psc_trigger_mux.sv | 187 ++++++++++++++++++
 tb/tb_psc_trigger_mux.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psc_trigger_mux.sv
// rtl/psc_trigger_mux.sv - round-robin EVR trigger arbiter with framed CRC-8 serial PSC output
// Optional per-frame timestamp byte: define PSC_TRIG_TIMESTAMP_EN.
module psc_trigger_mux #(
   parameter int         NUM_CH    = 4,
   parameter int         CLK_DIV   = 5,
   parameter logic [7:0] SYNC_BYTE = 8'hBC,
   parameter logic [7:0] CRC_POLY  = 8'h07,
   parameter int         GAP_BITS  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] trig_n,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              ovr_clear,
   output logic              psc_output,
   output logic              bit_stb,
   output logic              busy,
   output logic              frame_done,
   output logic [NUM_CH-1:0] overrun
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BW = (GAP_BITS > 10) ? $clog2(GAP_BITS) : 4;

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CHAN, S_SEQ, S_TS, S_CRC, S_GAP} state_t;
   state_t state, state_nxt;

   logic [DW-1:0]     div_cnt;
   logic [NUM_CH-1:0] sync1, sync2, sync3, fall, accept, ovr_set, grant_clr, pending;
   logic [CW-1:0]     rr_ptr, grant;
   logic [BW-1:0]     bit_idx, bit_idx_nxt;
   logic [7:0]        chan_q, seq, seq_q, crc_val, tx_byte;
   logic              bit_last, take, line_nxt;

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int b = 0; b < 8; b++)
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      return c;
   endfunction

   always_ff @(posedge clk or posedge reset)
      if (reset)                              div_cnt <= '0;
      else if (div_cnt == DW'(CLK_DIV - 1))   div_cnt <= '0;
      else                                    div_cnt <= div_cnt + 1'b1;

   assign bit_stb = (div_cnt == DW'(CLK_DIV - 1));

   // Synchroniser flops reset high so an idle (high) trigger line never looks like an edge.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
         sync3 <= '1;
      end else begin
         sync1 <= trig_n;
         sync2 <= sync1;
         sync3 <= sync2;
      end

   assign fall      = sync3 & ~sync2 & ch_enable;
   assign grant_clr = take ? (NUM_CH'(1) << grant) : '0;
   assign accept    = fall & (~pending | grant_clr);
   assign ovr_set   = fall & pending & ~grant_clr;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         pending <= ((pending & ~grant_clr) | accept) & ch_enable;
         overrun <= ovr_set | (overrun & ~{NUM_CH{ovr_clear}});
      end

   // First pending channel at or after rr_ptr; the lowest offset is assigned last and wins.
   always_comb begin
      int s;
      logic [CW-1:0] idx;
      grant = '0;
      s     = 0;
      idx   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         s = int'(rr_ptr) + k;
         if (s >= NUM_CH) s = s - NUM_CH;
         idx = CW'(s);
         if (pending[idx]) grant = idx;
      end
   end

`ifdef PSC_TRIG_TIMESTAMP_EN
   logic [7:0] ts_cnt, ts_q;
   logic [7:0] ts [NUM_CH];

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ts_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) ts[i] <= '0;
      end else begin
         if (bit_stb) ts_cnt <= ts_cnt + 1'b1;
         for (int i = 0; i < NUM_CH; i++)
            if (accept[i]) ts[i] <= ts_cnt;
      end

   assign crc_val = crc8_byte(crc8_byte(crc8_byte(8'h00, chan_q), seq_q), ts_q);
`else
   assign crc_val = crc8_byte(crc8_byte(8'h00, chan_q), seq_q);
`endif

   assign bit_last = (state == S_GAP) ? (bit_idx == BW'(GAP_BITS - 1)) : (bit_idx == BW'(9));
   // A request waiting at the end of the gap starts the next frame with no idle period.
   assign take = bit_stb && (|pending) && ((state == S_IDLE) || ((state == S_GAP) && bit_last));

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= S_IDLE;
         bit_idx <= '0;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_idx_nxt;
      end

   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      if (take) begin
         state_nxt = S_SYNC;
      end else if (bit_stb && bit_last) begin
         case (state)
            S_SYNC:  state_nxt = S_CHAN;
            S_CHAN:  state_nxt = S_SEQ;
`ifdef PSC_TRIG_TIMESTAMP_EN
            S_SEQ:   state_nxt = S_TS;
            S_TS:    state_nxt = S_CRC;
`else
            S_SEQ:   state_nxt = S_CRC;
`endif
            S_CRC:   state_nxt = S_GAP;
            default: state_nxt = S_IDLE;
         endcase
      end
      if (bit_stb)
         bit_idx_nxt = (take || bit_last || state == S_IDLE) ? '0 : bit_idx + 1'b1;
   end

   always_comb begin
      case (state_nxt)
         S_CHAN:  tx_byte = chan_q;
         S_SEQ:   tx_byte = seq_q;
`ifdef PSC_TRIG_TIMESTAMP_EN
         S_TS:    tx_byte = ts_q;
`endif
         S_CRC:   tx_byte = crc_val;
         default: tx_byte = SYNC_BYTE;
      endcase
      line_nxt = 1'b1;
      if (state_nxt != S_IDLE && state_nxt != S_GAP) begin
         if (bit_idx_nxt == '0)            line_nxt = 1'b0;
         else if (bit_idx_nxt <= BW'(8))   line_nxt = tx_byte[3'(bit_idx_nxt - 1'b1)];
      end
      busy       = (state != S_IDLE);
      frame_done = bit_stb && (state == S_GAP) && bit_last;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         psc_output <= 1'b1;
         rr_ptr     <= '0;
         seq        <= '0;
         seq_q      <= '0;
         chan_q     <= '0;
`ifdef PSC_TRIG_TIMESTAMP_EN
         ts_q       <= '0;
`endif
      end else begin
         if (bit_stb)    psc_output <= line_nxt;
         if (frame_done) seq <= seq + 1'b1;
         if (take) begin
            rr_ptr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            chan_q <= 8'(grant);
            seq_q  <= frame_done ? seq + 1'b1 : seq;
`ifdef PSC_TRIG_TIMESTAMP_EN
            ts_q   <= ts[grant];
`endif
         end
      end
endmodule

// File: tb/tb_psc_trigger_mux.sv
// tb/tb_psc_trigger_mux.sv - directed self-checking bench for psc_trigger_mux (default build)
module tb_psc_trigger_mux;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] trig_n = 4'hF;
   logic [3:0] ch_enable = 4'hF;
   logic       ovr_clear = 1'b0;
   logic       psc_output, bit_stb, busy, frame_done;
   logic [3:0] overrun;

   int n_cmp = 0;
   int n_err = 0;

   psc_trigger_mux dut (
      .clk(clk), .reset(reset), .trig_n(trig_n), .ch_enable(ch_enable),
      .ovr_clear(ovr_clear), .psc_output(psc_output), .bit_stb(bit_stb),
      .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #10 clk = ~clk;

   // Line decoder: samples each bit period just before it ends.
   logic [7:0] rx_mem [0:1023];
   int         rx_wr = 0, fd_cnt = 0, busy_cnt = 0, busy_rise = 0, stop_err = 0;
   logic [7:0] mon_byte = 8'h00;
   logic [3:0] mon_bit = 4'd0;
   logic       mon_active = 1'b0, busy_d = 1'b0;

   always @(negedge clk) begin
      busy_d <= busy;
      if (reset) begin
         mon_active <= 1'b0;
         mon_bit    <= 4'd0;
      end else begin
         if (busy) busy_cnt <= busy_cnt + 1;
         if (busy && !busy_d) busy_rise <= busy_rise + 1;
         if (frame_done) fd_cnt <= fd_cnt + 1;
         if (bit_stb) begin
            if (!mon_active) begin
               if (psc_output === 1'b0) begin
                  mon_active <= 1'b1;
                  mon_bit    <= 4'd0;
               end
            end else if (mon_bit < 4'd8) begin
               mon_byte <= {psc_output, mon_byte[7:1]};
               mon_bit  <= mon_bit + 4'd1;
            end else begin
               if (psc_output !== 1'b1) stop_err <= stop_err + 1;
               rx_mem[rx_wr[9:0]] <= mon_byte;
               rx_wr      <= rx_wr + 1;
               mon_active <= 1'b0;
            end
         end
      end
   end

   // Reference CRC: remainder of {a,b}*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] crc_ref(input logic [7:0] a, input logic [7:0] b);
      logic [23:0] r;
      r = {a, b, 8'h00};
      for (int i = 23; i >= 8; i--)
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      return r[7:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
   endtask

   task automatic pulse(input logic [3:0] mask);
      trig_n = trig_n & ~mask;
      tick(4);
      trig_n = trig_n | mask;
   endtask

   task automatic wait_fd(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (fd_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset;
      int bad, per;
      bit found;
      reset = 1'b1;
      tick(2);
      n_cmp++; if (psc_output !== 1'b1) begin n_err++; $display("FAIL rst_line: got %b want 1", psc_output); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (bit_stb !== 1'b0) begin n_err++; $display("FAIL rst_bit_stb: got %b want 0", bit_stb); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
      n_cmp++; if (overrun !== 4'h0) begin n_err++; $display("FAIL rst_overrun: got %h want 0", overrun); end
      reset = 1'b0;
      bad = 0;
      repeat (1000) begin
         tick(1);
         if (psc_output !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (bit_stb === 1'b1) found = 1'b1;
         else tick(1);
      end
      per = 0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         per++;
         if (bit_stb === 1'b1) break;
      end
      n_cmp++; if (!found || per != 5) begin n_err++; $display("FAIL bit_stb_period: got %0d want 5", per); end
   endtask

   task automatic test_single;
      int bfd, brx, bbusy;
      bit ok;
      do_reset;
      bfd = fd_cnt; brx = rx_wr; bbusy = busy_cnt;
      pulse(4'h1);
      wait_fd(bfd + 1, 400, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: got 0 frames want 1"); end
      n_cmp++; if (busy_cnt - bbusy != 210) begin n_err++; $display("FAIL single_busy_len: got %0d want 210", busy_cnt - bbusy); end
      n_cmp++; if (rx_wr - brx != 4) begin n_err++; $display("FAIL single_nbytes: got %0d want 4", rx_wr - brx); end
      n_cmp++;
      if ({rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]} !== 32'hBC000000) begin
         n_err++;
         $display("FAIL single_bytes: got %h %h %h %h want bc 00 00 00", rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]);
      end
      tick(50);
      n_cmp++; if (fd_cnt - bfd != 1) begin n_err++; $display("FAIL single_fd_once: got %0d want 1", fd_cnt - bfd); end
      brx = rx_wr;
      pulse(4'h1);
      wait_fd(bfd + 2, 400, ok);
      n_cmp++;
      if (!ok || {rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]} !== 32'hBC000107) begin
         n_err++;
         $display("FAIL seq1_bytes: got %h %h %h %h want bc 00 01 07", rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]);
      end
   endtask

   task automatic test_chan1;
      int bfd, brx;
      bit ok;
      do_reset;
      bfd = fd_cnt; brx = rx_wr;
      pulse(4'h2);
      wait_fd(bfd + 1, 400, ok);
      n_cmp++;
      if (!ok || {rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]} !== 32'hBC010015) begin
         n_err++;
         $display("FAIL chan1_bytes: got %h %h %h %h want bc 01 00 15", rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] masks [4];
      int         nfr [4];
      int         exp_ch [9];
      int         k, bfd, brx, brise;
      logic [7:0] ch, sq, cr, sy;
      bit         ok;
      masks  = '{4'hF, 4'h9, 4'h2, 4'h9};
      nfr    = '{4, 2, 1, 2};
      exp_ch = '{0, 1, 2, 3, 0, 3, 1, 3, 0};
      k = 0;
      do_reset;
      for (int r = 0; r < 4; r++) begin
         bfd = fd_cnt; brx = rx_wr; brise = busy_rise;
         pulse(masks[r]);
         wait_fd(bfd + nfr[r], nfr[r] * 210 + 200, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout round %0d: got %0d frames want %0d", r, fd_cnt - bfd, nfr[r]); end
         n_cmp++; if (busy_rise - brise != 1) begin n_err++; $display("FAIL rr_back_to_back round %0d: got %0d busy rises want 1", r, busy_rise - brise); end
         for (int f = 0; f < nfr[r]; f++) begin
            sy = rx_mem[10'(brx + 4*f)];
            ch = rx_mem[10'(brx + 4*f + 1)];
            sq = rx_mem[10'(brx + 4*f + 2)];
            cr = rx_mem[10'(brx + 4*f + 3)];
            n_cmp++;
            if (sy !== 8'hBC || ch !== 8'(exp_ch[k]) || sq !== 8'(k) || cr !== crc_ref(8'(exp_ch[k]), 8'(k))) begin
               n_err++;
               $display("FAIL rr_frame %0d: got %h %h %h %h want bc %h %h %h", k, sy, ch, sq, cr, 8'(exp_ch[k]), 8'(k), crc_ref(8'(exp_ch[k]), 8'(k)));
            end
            k++;
         end
      end
   endtask

   task automatic test_overrun;
      int bfd, brx;
      bit ok;
      do_reset;
      bfd = fd_cnt; brx = rx_wr;
      pulse(4'h1);
      for (int c = 0; c < 50 && busy !== 1'b1; c++) tick(1);
      tick(20);
      pulse(4'h4);
      tick(20);
      n_cmp++; if (overrun !== 4'h0) begin n_err++; $display("FAIL ovr_first_edge: got %h want 0", overrun); end
      pulse(4'h4);
      tick(10);
      n_cmp++; if (overrun !== 4'h4) begin n_err++; $display("FAIL ovr_set: got %h want 4", overrun); end
      wait_fd(bfd + 2, 700, ok);
      tick(400);
      n_cmp++; if (fd_cnt - bfd != 2) begin n_err++; $display("FAIL ovr_frames: got %0d want 2", fd_cnt - bfd); end
      n_cmp++; if (rx_mem[10'(brx+5)] !== 8'h02) begin n_err++; $display("FAIL ovr_chan: got %h want 02", rx_mem[10'(brx+5)]); end
      n_cmp++; if (overrun !== 4'h4) begin n_err++; $display("FAIL ovr_sticky: got %h want 4", overrun); end
      ovr_clear = 1'b1;
      tick(1);
      ovr_clear = 1'b0;
      tick(1);
      n_cmp++; if (overrun !== 4'h0) begin n_err++; $display("FAIL ovr_clear: got %h want 0", overrun); end
   endtask

   task automatic test_disable;
      int bfd, bbusy;
      do_reset;
      bfd = fd_cnt; bbusy = busy_cnt;
      ch_enable = 4'b1101;
      pulse(4'h2);
      tick(300);
      n_cmp++; if (fd_cnt - bfd != 0 || busy_cnt - bbusy != 0) begin n_err++; $display("FAIL dis_no_frame: got %0d frames %0d busy cycles want 0 0", fd_cnt - bfd, busy_cnt - bbusy); end
      n_cmp++; if (overrun !== 4'h0) begin n_err++; $display("FAIL dis_overrun: got %h want 0", overrun); end
      ch_enable = 4'hF;
      tick(300);
      n_cmp++; if (fd_cnt - bfd != 0) begin n_err++; $display("FAIL dis_reenable: got %0d frames want 0", fd_cnt - bfd); end
   endtask

   task automatic test_abort;
      int bfd, brx;
      bit ok;
      do_reset;
      pulse(4'h1);
      for (int c = 0; c < 50 && busy !== 1'b1; c++) tick(1);
      tick(56);
      n_cmp++; if (psc_output !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL abort_in_chan: got line %b busy %b want 0 1", psc_output, busy); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (psc_output !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_immediate: got line %b busy %b want 1 0", psc_output, busy); end
      tick(2);
      reset = 1'b0;
      tick(2);
      bfd = fd_cnt; brx = rx_wr;
      pulse(4'h1);
      wait_fd(bfd + 1, 400, ok);
      n_cmp++;
      if (!ok || {rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]} !== 32'hBC000000) begin
         n_err++;
         $display("FAIL abort_restart: got %h %h %h %h want bc 00 00 00", rx_mem[10'(brx)], rx_mem[10'(brx+1)], rx_mem[10'(brx+2)], rx_mem[10'(brx+3)]);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_chan1;
      test_back_to_back;
      test_overrun;
      test_disable;
      test_abort;
      n_cmp++; if (stop_err != 0) begin n_err++; $display("FAIL stop_bits: got %0d bad stop bits want 0", stop_err); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
